// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_pkg
// Description : Shared definitions for the SRAM pin-sequencing controller.
//               Holds the FSM state encoding, the phase-counter width and a
//               helper that turns a phase length in cycles into the value
//               loaded into the down-counter on entry to that phase.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

    localparam int CNT_W   = 8;
    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_WSETUP  = 3'd1;
    localparam state_t S_WPULSE  = 3'd2;
    localparam state_t S_WHOLD   = 3'd3;
    localparam state_t S_RACCESS = 3'd4;

    // A phase of N cycles loads N-1 so that the phase ends on the edge where
    // the counter already reads zero.
    function automatic logic [CNT_W-1:0] phaseLoad(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_timer
// Description : Loadable 8-bit down-counter used to time each SRAM access
//               phase. Counts down to zero and holds there.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high clear
//               i_load    - load i_loadVal on the next edge
//               i_loadVal - value to load
//               o_done    - counter is zero
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl_timer
    import sram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_loadVal,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl
// Description : Clocked host request/ready port to asynchronous SRAM pins.
//               Each access is split into timed phases (write: setup, pulse,
//               hold; read: access) whose lengths are parameters. All pin
//               outputs and the data-bus drive enable come straight from
//               flops, decoded from the next state.
// Ports       : CK, RST          - clock / async active-high reset
//               REQ, RW          - host request, 1 = write
//               ADDR, WDATA      - host address / write data
//               READY            - idle, request can be accepted
//               RDATA, RVALID    - read data and its one-cycle valid pulse
//               A, D             - RAM address / bidirectional data
//               WE, OE, CS       - RAM strobes, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int T_SETUP  = 1,
    parameter int T_WPULSE = 1,
    parameter int T_HOLD   = 1,
    parameter int T_READ   = 2
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          REQ,
    input  logic          RW,
    input  logic [AW-1:0] ADDR,
    input  logic [DW-1:0] WDATA,
    output logic          READY,
    output logic [DW-1:0] RDATA,
    output logic          RVALID,
    output logic [AW-1:0] A,
    inout  wire  [DW-1:0] D,
    output logic          WE,
    output logic          OE,
    output logic          CS
);

    state_t           r_state;
    state_t           w_nextState;
    logic             w_load;
    logic [CNT_W-1:0] w_loadVal;
    logic             w_accept;
    logic             w_timerDone;
    logic             w_readDone;

    logic             r_ready;
    logic             r_rvalid;
    logic [DW-1:0]    r_rdata;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic             r_dDrive;
    logic             r_we;
    logic             r_oe;
    logic             r_cs;

    sram_ctrl_timer u_timer (
        .clk       (CK),
        .rst       (RST),
        .i_load    (w_load),
        .i_loadVal (w_loadVal),
        .o_done    (w_timerDone)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------
    // Next state and phase-counter loading. RW needs no register of its
    // own: the branch taken at acceptance is remembered by the state.
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_loadVal   = '0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (REQ) begin
                    w_accept = 1'b1;
                    w_load   = 1'b1;
                    if (RW) begin
                        w_nextState = S_WSETUP;
                        w_loadVal   = phaseLoad(T_SETUP);
                    end else begin
                        w_nextState = S_RACCESS;
                        w_loadVal   = phaseLoad(T_READ);
                    end
                end
            end
            S_WSETUP: begin
                if (w_timerDone) begin
                    w_nextState = S_WPULSE;
                    w_load      = 1'b1;
                    w_loadVal   = phaseLoad(T_WPULSE);
                end
            end
            S_WPULSE: begin
                if (w_timerDone) begin
                    w_nextState = S_WHOLD;
                    w_load      = 1'b1;
                    w_loadVal   = phaseLoad(T_HOLD);
                end
            end
            S_WHOLD: begin
                if (w_timerDone) begin
                    w_nextState = S_IDLE;
                end
            end
            S_RACCESS: begin
                if (w_timerDone) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign w_readDone = (r_state == S_RACCESS) && w_timerDone;

    // ------------------------------------------------------------------
    // Registered pins. Decoding from the next state makes each pin take
    // its phase level in the same cycle the state enters that phase,
    // while REQ only ever reaches the pins through a flop.
    // ------------------------------------------------------------------
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_ready  <= 1'b1;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_dDrive <= 1'b0;
            r_we     <= 1'b1;
            r_oe     <= 1'b1;
            r_cs     <= 1'b1;
        end else begin
            r_ready  <= (w_nextState == S_IDLE);
            r_cs     <= (w_nextState == S_IDLE);
            r_we     <= (w_nextState != S_WPULSE);
            r_oe     <= (w_nextState != S_RACCESS);
            r_dDrive <= (w_nextState == S_WSETUP) ||
                        (w_nextState == S_WPULSE) ||
                        (w_nextState == S_WHOLD);
            r_rvalid <= w_readDone;
            if (w_accept) begin
                r_addr  <= ADDR;
                r_wdata <= WDATA;
            end
            // The RAM has been driving D for the whole access window here.
            if (w_readDone) begin
                r_rdata <= D;
            end
        end
    end

    assign READY  = r_ready;
    assign RVALID = r_rvalid;
    assign RDATA  = r_rdata;
    assign A      = r_addr;
    assign WE     = r_we;
    assign OE     = r_oe;
    assign CS     = r_cs;
    assign D      = r_dDrive ? r_wdata : {DW{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_ctrl
// Description : Directed self-checking bench for sram_ctrl. One controller
//               with default timing and one with T_SETUP=2, T_WPULSE=4, each
//               attached to a small behavioural asynchronous RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;

    logic       CK;
    logic       RST;
    logic       REQ;
    logic       REQ2;
    logic       RW;
    logic [7:0] ADDR;
    logic [7:0] WDATA;

    logic       READY,  RVALID,  WE,  OE,  CS;
    logic       READY2, RVALID2, WE2, OE2, CS2;
    logic [7:0] RDATA,  A;
    logic [7:0] RDATA2, A2;
    wire  [7:0] D;
    wire  [7:0] D2;

    logic [7:0] mem  [0:255];
    logic [7:0] mem2 [0:255];

    int total = 0;
    int bad   = 0;
    int weLow;

    sram_ctrl dut (
        .CK(CK), .RST(RST), .REQ(REQ), .RW(RW), .ADDR(ADDR), .WDATA(WDATA),
        .READY(READY), .RDATA(RDATA), .RVALID(RVALID),
        .A(A), .D(D), .WE(WE), .OE(OE), .CS(CS)
    );

    sram_ctrl #(.T_SETUP(2), .T_WPULSE(4), .T_HOLD(1), .T_READ(2)) dut2 (
        .CK(CK), .RST(RST), .REQ(REQ2), .RW(RW), .ADDR(ADDR), .WDATA(WDATA),
        .READY(READY2), .RDATA(RDATA2), .RVALID(RVALID2),
        .A(A2), .D(D2), .WE(WE2), .OE(OE2), .CS(CS2)
    );

    // Behavioural RAMs: write on WE rising while selected, drive D while
    // selected and output-enabled. Reset fills them with a sentinel.
    assign D  = (!CS  && !OE  && WE)  ? mem[A]   : 8'bz;
    assign D2 = (!CS2 && !OE2 && WE2) ? mem2[A2] : 8'bz;

    always @(posedge WE or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        end else if (!CS) begin
            mem[A] = D;
        end
    end

    always @(posedge WE2 or posedge RST) begin
        if (RST) begin
            for (int j = 0; j < 256; j++) mem2[j] = 8'hEE;
        end else if (!CS2) begin
            mem2[A2] = D2;
        end
    end

    initial begin
        CK = 1'b0;
        #20;
        forever #5 CK = ~CK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    initial begin
        RST = 1'b0; REQ = 1'b0; REQ2 = 1'b0; RW = 1'b0; ADDR = 8'h00; WDATA = 8'h00;

        // 1: asynchronous reset, clock not yet running
        #1 RST = 1'b1;
        #1;
        check("rst_cs",     CS,  1'b1);
        check("rst_we",     WE,  1'b1);
        check("rst_oe",     OE,  1'b1);
        check("rst_drive",  dut.r_dDrive, 1'b0);
        check("rst_ready",  READY,  1'b1);
        check("rst_rvalid", RVALID, 1'b0);
        check("rst_rdata",  RDATA,  8'h00);
        check("rst_a",      A,      8'h00);
        #8 RST = 1'b0;
        tick;

        // 2: write 0x12 = 0xA5
        REQ = 1'b1; RW = 1'b1; ADDR = 8'h12; WDATA = 8'hA5;
        tick;                                   // cycle 1: WSETUP
        REQ = 1'b0;
        check("w_c1_cs",    CS,    1'b0);
        check("w_c1_we",    WE,    1'b1);
        check("w_c1_d",     D,     8'hA5);
        check("w_c1_a",     A,     8'h12);
        check("w_c1_ready", READY, 1'b0);
        tick;                                   // cycle 2: WPULSE
        check("w_c2_cs",    CS,    1'b0);
        check("w_c2_we",    WE,    1'b0);
        check("w_c2_oe",    OE,    1'b1);
        check("w_c2_d",     D,     8'hA5);
        tick;                                   // cycle 3: WHOLD
        check("w_c3_cs",    CS,    1'b0);
        check("w_c3_we",    WE,    1'b1);
        check("w_c3_d",     D,     8'hA5);
        check("w_c3_a",     A,     8'h12);
        tick;                                   // cycle 4: IDLE
        check("w_c4_ready", READY, 1'b1);
        check("w_c4_cs",    CS,    1'b1);
        check("w_c4_drive", dut.r_dDrive, 1'b0);
        check("w_mem12",    mem[8'h12], 8'hA5);

        // 3: read 0x12
        REQ = 1'b1; RW = 1'b0; ADDR = 8'h12;
        tick;                                   // cycle 1: RACCESS
        REQ = 1'b0;
        check("r_c1_cs",     CS,     1'b0);
        check("r_c1_oe",     OE,     1'b0);
        check("r_c1_we",     WE,     1'b1);
        check("r_c1_drive",  dut.r_dDrive, 1'b0);
        tick;                                   // cycle 2: RACCESS
        check("r_c2_oe",     OE,     1'b0);
        check("r_c2_d",      D,      8'hA5);
        check("r_c2_rvalid", RVALID, 1'b0);
        tick;                                   // cycle 3: IDLE, valid
        check("r_c3_rvalid", RVALID, 1'b1);
        check("r_c3_rdata",  RDATA,  8'hA5);
        check("r_c3_cs",     CS,     1'b1);
        check("r_c3_oe",     OE,     1'b1);
        check("r_c3_ready",  READY,  1'b1);
        tick;
        check("r_c4_rvalid", RVALID, 1'b0);
        check("r_c4_rdata",  RDATA,  8'hA5);

        // 4: REQ held high, read 0x12 then write 0x34 = 0x5A
        REQ = 1'b1; RW = 1'b0; ADDR = 8'h12;
        tick;                                   // cycle 1: RACCESS
        RW = 1'b1; ADDR = 8'h34; WDATA = 8'h5A;
        check("b2b_c1_a",   A, 8'h12);
        tick;                                   // cycle 2: still reading 0x12
        check("b2b_c2_a",   A, 8'h12);
        check("b2b_c2_oe",  OE, 1'b0);
        tick;                                   // cycle 3: turnaround
        check("b2b_c3_rvalid", RVALID, 1'b1);
        check("b2b_c3_rdata",  RDATA,  8'hA5);
        check("b2b_c3_cs",     CS, 1'b1);
        check("b2b_c3_oe",     OE, 1'b1);
        check("b2b_c3_we",     WE, 1'b1);
        check("b2b_c3_drive",  dut.r_dDrive, 1'b0);
        tick;                                   // cycle 4: WSETUP
        REQ = 1'b0;
        check("b2b_c4_cs",    CS, 1'b0);
        check("b2b_c4_d",     D,  8'h5A);
        check("b2b_c4_a",     A,  8'h34);
        check("b2b_c4_ready", READY, 1'b0);
        tick;                                   // cycle 5: WPULSE
        check("b2b_c5_we",    WE, 1'b0);
        check("b2b_c5_d",     D,  8'h5A);
        tick;
        tick;                                   // cycle 7: IDLE
        check("b2b_mem34", mem[8'h34], 8'h5A);
        REQ = 1'b1; RW = 1'b0; ADDR = 8'h34;
        tick;
        REQ = 1'b0;
        tick;
        tick;
        check("b2b_rd_rvalid", RVALID, 1'b1);
        check("b2b_rd_rdata",  RDATA,  8'h5A);

        // 5: T_SETUP=2, T_WPULSE=4, write 0x01 = 0xFF; a request to 0x02
        //    presented while busy must be ignored
        tick;
        REQ2 = 1'b1; RW = 1'b1; ADDR = 8'h01; WDATA = 8'hFF;
        tick;                                   // cycle 1
        ADDR = 8'h02; WDATA = 8'h11;
        weLow = 0;
        for (int c = 1; c <= 7; c++) begin
            check($sformatf("t5_c%0d_cs", c), CS2, 1'b0);
            check($sformatf("t5_c%0d_we", c), WE2, (c >= 3 && c <= 6) ? 1'b0 : 1'b1);
            check($sformatf("t5_c%0d_a",  c), A2,  8'h01);
            if (WE2 == 1'b0) weLow++;
            if (c == 5) REQ2 = 1'b0;
            tick;
        end
        check("t5_welow",  weLow, 4);
        check("t5_ready",  READY2, 1'b1);
        check("t5_cs_idle", CS2, 1'b1);
        tick;
        tick;
        check("t5_cs_after", CS2, 1'b1);
        check("t5_mem01", mem2[8'h01], 8'hFF);
        check("t5_mem02", mem2[8'h02], 8'hEE);

        // 6: reset during WPULSE of a write to 0x03
        REQ = 1'b1; RW = 1'b1; ADDR = 8'h03; WDATA = 8'h77;
        tick;                                   // cycle 1: WSETUP
        REQ = 1'b0;
        tick;                                   // cycle 2: WPULSE
        check("t6_we_low", WE, 1'b0);
        #2 RST = 1'b1;
        #1;
        check("t6_we",     WE, 1'b1);
        check("t6_cs",     CS, 1'b1);
        check("t6_oe",     OE, 1'b1);
        check("t6_drive",  dut.r_dDrive, 1'b0);
        check("t6_ready",  READY, 1'b1);
        RST = 1'b0;
        tick;
        check("t6_ready_a",  READY,  1'b1);
        check("t6_rvalid_a", RVALID, 1'b0);
        tick;
        check("t6_rvalid_b", RVALID, 1'b0);
        check("t6_cs_b",     CS,     1'b1);
        check("t6_rdata",    RDATA,  8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
